// File: rtl/cont_delay_pkg.sv
// Shared types and limits for the inertial delay stage.
package cont_delay_pkg;

    // Scheduler state: nothing scheduled, or one update waiting to commit.
    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_t;

    // Countdown timer for the scheduled update.
    typedef logic [7:0] timer_t;

    // Largest total delay the 8-bit timer can represent.
    localparam int MAX_DELAY = 255;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: counts inc pulses, sticks at all-ones.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // Increment on each inc cycle until the counter is full, then hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/inertial_net_stage.sv
// Inertial delay stage: din reaches dout D cycles later only if it held
// steady for the whole window; shorter pulses are swallowed and counted.
//
// Handshake note: there is no valid/ready pair. din is sampled on every
// rising edge; update is a one-cycle strobe marking the cycle after dout
// changed, and pending mirrors the scheduler state for observation.
module inertial_net_stage
    import cont_delay_pkg::*;
#(
    parameter int                 WIDTH        = 1,
    parameter int                 ASSIGN_DELAY = 1,
    parameter int                 NET_DELAY    = 1,
    parameter logic [WIDTH-1:0]   RESET_VAL    = '0,
    parameter int                 CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             pending,
    output logic             update,
    output logic [CNT_W-1:0] cancel_cnt
);

    // Assignment and net delays simply add; one timer covers both.
    localparam int     TOTAL_DELAY = ASSIGN_DELAY + NET_DELAY;
    localparam timer_t RELOAD      = timer_t'(TOTAL_DELAY - 1);

    generate
        if ((TOTAL_DELAY < 1) || (TOTAL_DELAY > MAX_DELAY)) begin : g_bad_delay
            $error("inertial_net_stage: ASSIGN_DELAY + NET_DELAY must be in 1..255");
        end
    endgenerate

    state_t           state;
    timer_t           cnt;
    logic [WIDTH-1:0] pend_val;
    logic             cancel_evt;

    // A scheduled value abandoned before its commit edge (either dropped
    // back to dout or replaced by a third value) counts as one cancel.
    // Commit edges are excluded because cnt == 0 there.
    always_comb begin
        cancel_evt = 1'b0;
        if ((state == PENDING) && (cnt != '0) && (din != pend_val)) begin
            cancel_evt = 1'b1;
        end
    end

    // Scheduler FSM with registered dout/update; a commit always wins over
    // a din change sampled on the same edge, and that change is rescheduled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            pend_val <= RESET_VAL;
            dout     <= RESET_VAL;
            update   <= 1'b0;
        end else begin
            update <= 1'b0;
            case (state)
                IDLE: begin
                    if (din != dout) begin
                        state    <= PENDING;
                        pend_val <= din;
                        cnt      <= RELOAD;
                    end
                end
                PENDING: begin
                    if (cnt == '0) begin
                        dout   <= pend_val;
                        update <= 1'b1;
                        if (din == pend_val) begin
                            state <= IDLE;
                        end else begin
                            pend_val <= din;
                            cnt      <= RELOAD;
                        end
                    end else if (din == pend_val) begin
                        cnt <= cnt - 8'd1;
                    end else if (din == dout) begin
                        state <= IDLE;
                    end else begin
                        pend_val <= din;
                        cnt      <= RELOAD;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign pending = (state == PENDING);

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_cancel_counter (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (cancel_evt),
        .count(cancel_cnt)
    );

endmodule

// File: tb/tb_inertial_net_stage.sv
// Bench for inertial_net_stage: three instances share din/rst_n
// (D=2 CNT_W=16, D=2 CNT_W=2, D=3 with non-zero RESET_VAL) and are
// compared against a run-length reference model through a scoreboard.
module tb_inertial_net_stage;

  localparam int NK = 3;

  logic        clk;
  logic        rst_n;
  logic [7:0]  din;

  logic [7:0]  dout0, dout1, dout2;
  logic        pend0, pend1, pend2;
  logic        upd0, upd1, upd2;
  logic [15:0] cc0;
  logic [1:0]  cc1;
  logic [15:0] cc2;

  // Expected entry: {dout[25:18], pending[17], update[16], cancel_cnt[15:0]}
  logic [25:0] exp_q[$];

  int checks = 0;
  int failures = 0;
  int cycle_n = 0;

  // Per-instance configuration mirrored from the instantiations below.
  int          cfg_d[NK]     = '{2, 2, 3};
  logic [7:0]  cfg_rv[NK]    = '{8'h00, 8'h00, 8'h5A};
  int          cfg_max[NK]   = '{65535, 3, 65535};

  // Reference model state: the current din run and whether it is scheduled.
  logic [7:0]  m_dout[NK];
  logic [7:0]  m_run_val[NK];
  int          m_run_start[NK];
  bit          m_sched[NK];
  bit          m_first[NK];
  bit          m_upd[NK];
  int          m_cancels[NK];
  int          edge_n = 0;

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  inertial_net_stage #(
    .WIDTH(8), .ASSIGN_DELAY(1), .NET_DELAY(1), .RESET_VAL(8'h00), .CNT_W(16)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .din(din),
    .dout(dout0), .pending(pend0), .update(upd0), .cancel_cnt(cc0)
  );

  inertial_net_stage #(
    .WIDTH(8), .ASSIGN_DELAY(1), .NET_DELAY(1), .RESET_VAL(8'h00), .CNT_W(2)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .din(din),
    .dout(dout1), .pending(pend1), .update(upd1), .cancel_cnt(cc1)
  );

  inertial_net_stage #(
    .WIDTH(8), .ASSIGN_DELAY(2), .NET_DELAY(1), .RESET_VAL(8'h5A), .CNT_W(16)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .din(din),
    .dout(dout2), .pending(pend2), .update(upd2), .cancel_cnt(cc2)
  );

  function automatic logic [25:0] actual(input int k);
    case (k)
      0:       return {dout0, pend0, upd0, cc0};
      1:       return {dout1, pend1, upd1, 14'd0, cc1};
      default: return {dout2, pend2, upd2, cc2};
    endcase
  endfunction

  task automatic check(input string name, input int k, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[dut%0d] cycle %0d: got %h expected %h", name, k, cycle_n, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Inertial rule in run terms: a run of value v starting at edge s is
  // scheduled if v differs from dout just after edge s; it commits at
  // s+D if the run is still alive, and a scheduled run that ends earlier
  // is one cancel. Reset wipes everything and breaks the current run.
  task automatic model_edge();
    logic [25:0] e;
    int c;
    for (int k = 0; k < NK; k++) begin
      if (!rst_n) begin
        m_dout[k]    = cfg_rv[k];
        m_sched[k]   = 1'b0;
        m_first[k]   = 1'b1;
        m_upd[k]     = 1'b0;
        m_cancels[k] = 0;
      end else begin
        m_upd[k] = 1'b0;
        if (m_sched[k] && (edge_n == m_run_start[k] + cfg_d[k])) begin
          m_dout[k]  = m_run_val[k];
          m_upd[k]   = 1'b1;
          m_sched[k] = 1'b0;
        end
        if (m_first[k] || (din != m_run_val[k])) begin
          if (m_sched[k]) m_cancels[k]++;
          m_run_val[k]   = din;
          m_run_start[k] = edge_n;
          m_sched[k]     = (din != m_dout[k]);
          m_first[k]     = 1'b0;
        end
      end
      c = (m_cancels[k] > cfg_max[k]) ? cfg_max[k] : m_cancels[k];
      e = {m_dout[k], m_sched[k], m_upd[k], c[15:0]};
      exp_q.push_back(e);
    end
    edge_n++;
  endtask

  // ---------------- driver ----------------
  // Inputs change 1 time unit after the falling edge; a falling rst_n is
  // also checked for its asynchronous effect before the next rising edge.
  task automatic drive(input logic rst_v, input logic [7:0] d);
    logic prev_rst;
    logic [25:0] a;
    @(negedge clk);
    #1;
    prev_rst = rst_n;
    rst_n = rst_v;
    din = d;
    if (prev_rst && !rst_v) begin
      #1;
      for (int k = 0; k < NK; k++) begin
        a = actual(k);
        check("async_rst_dout", k, {8'd0, a[25:18]}, {8'd0, cfg_rv[k]});
        check("async_rst_pending", k, {15'd0, a[17]}, 16'd0);
        check("async_rst_update", k, {15'd0, a[16]}, 16'd0);
        check("async_rst_cancel", k, a[15:0], 16'd0);
      end
    end
    @(posedge clk);
    model_edge();
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00);
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [25:0] e;
    logic [25:0] a;
    forever begin
      @(negedge clk);
      if (exp_q.size() >= NK) begin
        cycle_n++;
        for (int k = 0; k < NK; k++) begin
          e = exp_q.pop_front();
          a = actual(k);
          check("dout", k, {8'd0, a[25:18]}, {8'd0, e[25:18]});
          check("pending", k, {15'd0, a[17]}, {15'd0, e[17]});
          check("update", k, {15'd0, a[16]}, {15'd0, e[16]});
          check("cancel_cnt", k, a[15:0], e[15:0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] d;
    int r;
    rst_n = 1'b0;
    din = 8'h00;
    for (int k = 0; k < NK; k++) begin
      m_dout[k] = cfg_rv[k];
      m_run_val[k] = 8'h00;
      m_run_start[k] = 0;
      m_sched[k] = 1'b0;
      m_first[k] = 1'b1;
      m_upd[k] = 1'b0;
      m_cancels[k] = 0;
    end

    // basic propagation 0 -> 5
    do_reset(3);
    for (int i = 0; i < 5; i++) drive(1'b1, 8'd5);
    // single-cycle glitch
    do_reset(2);
    drive(1'b1, 8'd5);
    for (int i = 0; i < 3; i++) drive(1'b1, 8'd0);
    // retarget chain 1, 2, 3
    do_reset(2);
    drive(1'b1, 8'd1);
    drive(1'b1, 8'd2);
    for (int i = 0; i < 4; i++) drive(1'b1, 8'd3);
    // commit colliding with a new value
    do_reset(2);
    drive(1'b1, 8'd7);
    drive(1'b1, 8'd7);
    for (int i = 0; i < 4; i++) drive(1'b1, 8'd9);
    // reset in the middle of a schedule
    do_reset(2);
    drive(1'b1, 8'd4);
    drive(1'b0, 8'd0);
    drive(1'b0, 8'd0);
    for (int i = 0; i < 4; i++) drive(1'b1, 8'd0);
    // six glitches to saturate the narrow counter
    do_reset(2);
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 8'd5);
      drive(1'b1, 8'd0);
    end
    drive(1'b1, 8'd0);

    // randomized traffic with holds, small-alphabet values and resets
    d = 8'h00;
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 99);
      if (r < 2) begin
        drive(1'b0, 8'($urandom_range(0, 255)));
      end else begin
        if (r < 55) begin
          d = d;
        end else if (r < 85) begin
          d = 8'($urandom_range(0, 3));
        end else if (r < 90) begin
          d = 8'h5A;
        end else begin
          d = 8'($urandom_range(0, 255));
        end
        drive(1'b1, d);
      end
    end

    @(negedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
